// File: rtl/posit_pack.sv
// Posit encoder: packs sign/regime/exponent/fraction fields into one
// rounded N-bit posit through a 3-stage valid/ready pipeline.
module posit_pack #(
  parameter  int N  = 16,
  parameter  int es = 2,
  localparam int Bs = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_rc,
  input  logic [Bs-1:0] in_regime,
  input  logic [es-1:0] in_exp,
  input  logic [N-es-1:0] in_mant,
  input  logic          in_zero,
  input  logic          in_inf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);

  localparam int W = 2 * N;

  logic en;
  logic v1, v2;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  // Stage 1: register fields, regime length and saturation class
  logic [Bs:0] len_d;
  logic        sat_d;

  assign sat_d = in_regime >= Bs'(N - 2);
  assign len_d = in_rc ? {1'b0, in_regime} + (Bs+1)'(2)
                       : {1'b0, in_regime} + (Bs+1)'(1);

  logic            s1_sign, s1_rc, s1_zero, s1_inf;
  logic            s1_satmax, s1_satmin;
  logic [Bs:0]     s1_len;
  logic [es-1:0]   s1_exp;
  logic [N-es-1:0] s1_mant;

  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign   <= in_sign;
      s1_rc     <= in_rc;
      s1_inf    <= in_inf;
      s1_zero   <= in_zero & ~in_inf;
      s1_satmax <= in_rc & sat_d;
      s1_satmin <= ~in_rc & sat_d;
      s1_len    <= len_d;
      s1_exp    <= in_exp;
      s1_mant   <= in_mant;
    end
  end

  // Stage 2: S = regime || exp || mant laid out MSB-first in a 2N word
  logic [W-1:0] reg_w;
  logic [W-1:0] fld_w;
  logic [W-1:0] s_w;

  always_comb begin
    if (s1_rc)
      reg_w = ~({W{1'b1}} >> (s1_len - 1'b1));
    else
      reg_w = {1'b1, {(W-1){1'b0}}} >> (s1_len - 1'b1);
    fld_w = {s1_exp, s1_mant, {N{1'b0}}} >> s1_len;
    s_w   = reg_w | fld_w;
  end

  logic           s2_sign, s2_zero, s2_inf;
  logic           s2_satmax, s2_satmin;
  logic [N-2:0]   s2_body;
  logic           s2_g, s2_st;

  always_ff @(posedge clk) begin
    if (en) begin
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_inf    <= s1_inf;
      s2_satmax <= s1_satmax;
      s2_satmin <= s1_satmin;
      s2_body   <= s_w[W-1 -: N-1];
      s2_g      <= s_w[W-N];
      s2_st     <= |s_w[W-N-1:0];
    end
  end

  // Stage 3: round to nearest even, saturate, apply sign and specials
  logic [N-2:0] body;
  logic [N-1:0] res;

  always_comb begin
    body = s2_body
         + {{(N-2){1'b0}}, s2_g & (s2_body[0] | s2_st)};
    if (s2_satmax)
      body = '1;
    else if (s2_satmin)
      body = {{(N-2){1'b0}}, 1'b1};
    res = {1'b0, body};
    if (s2_sign)
      res = -res;
    if (s2_inf)
      res = {1'b1, {(N-1){1'b0}}};
    else if (s2_zero)
      res = '0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      out_posit <= '0;
    else if (en)
      out_posit <= res;
  end

endmodule

// File: tb/tb_posit_pack.sv
// Directed bench for posit_pack (N=16, es=2): values, rounding,
// saturation, specials, backpressure and mid-stream reset.
module tb_posit_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic        in_rc;
  logic [3:0]  in_regime;
  logic [1:0]  in_exp;
  logic [13:0] in_mant;
  logic        in_zero;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_posit;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [23:0] stim_q[$];
  logic [15:0] got_q[$];
  int          cyc_q[$];

  posit_pack #(.N(16), .es(2)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sign(in_sign),
    .in_rc(in_rc),
    .in_regime(in_regime),
    .in_exp(in_exp),
    .in_mant(in_mant),
    .in_zero(in_zero),
    .in_inf(in_inf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_posit(out_posit)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  function automatic logic [23:0] mk(
    input logic s, input logic rc, input int r,
    input int e, input int m, input logic z, input logic i);
    return {s, rc, 4'(r), 2'(e), 14'(m), z, i};
  endfunction

  task automatic set_in(input logic [23:0] v);
    {in_sign, in_rc, in_regime, in_exp, in_mant, in_zero, in_inf} = v;
  endtask

  task automatic drive_stream();
    int guard;
    guard = 0;
    while (stim_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      set_in(stim_q[0]);
      in_valid = 1'b1;
      #2;
      if (in_ready) void'(stim_q.pop_front());
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (stim_q.size() != 0) begin
      errors++;
      $display("FAIL drive: %0d inputs never accepted, required 0",
               stim_q.size());
      stim_q.delete();
    end
  endtask

  task automatic collect(input int n);
    got_q.delete();
    cyc_q.delete();
    for (int c = 0; c < 60 && got_q.size() < n; c++) begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        got_q.push_back(out_posit);
        cyc_q.push_back(cyc);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_in('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b required 0", out_valid);
    end
    checks++;
    if (out_posit !== 16'h0000) begin
      errors++;
      $display("FAIL reset_posit: got %h required 0000", out_posit);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_latency();
    int cnt;
    @(negedge clk);
    set_in(mk(0, 1, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== 3) begin
      errors++;
      $display("FAIL latency: got %0d cycles required 3", cnt);
    end
    checks++;
    if (out_posit !== 16'h4000) begin
      errors++;
      $display("FAIL latency_val: got %h required 4000", out_posit);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] want [4];
    want = '{16'h4000, 16'hC000, 16'h6400, 16'h3800};
    stim_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    stim_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    stim_q.push_back(mk(0, 1, 1, 1, 0, 0, 0));
    stim_q.push_back(mk(0, 0, 1, 3, 0, 0, 0));
    fork
      drive_stream();
      collect(4);
    join
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("FAIL basic[%0d]: missing, required %h", i, want[i]);
      end else if (got_q[i] !== want[i]) begin
        errors++;
        $display("FAIL basic[%0d]: got %h required %h",
                 i, got_q[i], want[i]);
      end
    end
    checks++;
    if (got_q.size() != 4 || cyc_q[3] - cyc_q[0] != 3) begin
      errors++;
      $display("FAIL basic_rate: %0d outputs, not 1 per cycle, required 4 back to back",
               got_q.size());
    end
  endtask

  task automatic test_saturation();
    logic [15:0] want [4];
    want = '{16'h7FFF, 16'h7FFF, 16'h0001, 16'hFFFF};
    stim_q.push_back(mk(0, 1, 14, 0, 0, 0, 0));
    stim_q.push_back(mk(0, 1, 15, 3, 16'h3FFF, 0, 0));
    stim_q.push_back(mk(0, 0, 14, 2, 5, 0, 0));
    stim_q.push_back(mk(1, 0, 14, 0, 0, 0, 0));
    fork
      drive_stream();
      collect(4);
    join
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("FAIL sat[%0d]: missing, required %h", i, want[i]);
      end else if (got_q[i] !== want[i]) begin
        errors++;
        $display("FAIL sat[%0d]: got %h required %h",
                 i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [15:0] want [3];
    want = '{16'h7FFC, 16'h7FFD, 16'h7FFE};
    stim_q.push_back(mk(0, 1, 12, 1, 0, 0, 0));
    stim_q.push_back(mk(0, 1, 12, 1, 1, 0, 0));
    stim_q.push_back(mk(0, 1, 12, 3, 0, 0, 0));
    fork
      drive_stream();
      collect(3);
    join
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("FAIL round[%0d]: missing, required %h", i, want[i]);
      end else if (got_q[i] !== want[i]) begin
        errors++;
        $display("FAIL round[%0d]: got %h required %h",
                 i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [15:0] want [4];
    want = '{16'h0000, 16'h0000, 16'h8000, 16'h8000};
    stim_q.push_back(mk(0, 1, 3, 2, 5, 1, 0));
    stim_q.push_back(mk(1, 0, 2, 1, 7, 1, 0));
    stim_q.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    stim_q.push_back(mk(1, 1, 0, 0, 0, 1, 1));
    fork
      drive_stream();
      collect(4);
    join
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("FAIL special[%0d]: missing, required %h", i, want[i]);
      end else if (got_q[i] !== want[i]) begin
        errors++;
        $display("FAIL special[%0d]: got %h required %h",
                 i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] want [6];
    bit          pat [6];
    int          n;
    bit          stalled;
    logic [15:0] held;
    want = '{16'h4000, 16'hC000, 16'h6400,
             16'h3800, 16'h7FFC, 16'h7FFE};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    stim_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    stim_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    stim_q.push_back(mk(0, 1, 1, 1, 0, 0, 0));
    stim_q.push_back(mk(0, 0, 1, 3, 0, 0, 0));
    stim_q.push_back(mk(0, 1, 12, 1, 0, 0, 0));
    stim_q.push_back(mk(0, 1, 12, 3, 0, 0, 0));
    n = 0;
    stalled = 1'b0;
    held = '0;
    fork
      drive_stream();
      begin
        for (int c = 0; c < 80 && n < 6; c++) begin
          @(negedge clk);
          out_ready = pat[c % 6];
          #1;
          checks++;
          if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL bp_ready c%0d: got %b required %b",
                     c, in_ready, !(out_valid && !out_ready));
          end
          if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_posit !== held) begin
              errors++;
              $display("FAIL bp_hold c%0d: got v=%b %h required v=1 %h",
                       c, out_valid, out_posit, held);
            end
          end
          if (out_valid && out_ready) begin
            checks++;
            if (out_posit !== want[n]) begin
              errors++;
              $display("FAIL bp[%0d]: got %h required %h",
                       n, out_posit, want[n]);
            end
            n++;
          end
          stalled = out_valid && !out_ready;
          held = out_posit;
        end
      end
    join
    out_ready = 1'b1;
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs required 6", n);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_extra: got out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int cnt;
    out_ready = 1'b1;
    stim_q.push_back(mk(0, 1, 1, 1, 0, 0, 0));
    stim_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    stim_q.push_back(mk(0, 1, 12, 3, 0, 0, 0));
    drive_stream();
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_fill: got out_valid %b required 1", out_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_flush: got out_valid %b required 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
    set_in(mk(0, 0, 1, 3, 0, 0, 0));
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== 3) begin
      errors++;
      $display("FAIL rst_latency: got %0d cycles required 3", cnt);
    end
    checks++;
    if (out_posit !== 16'h3800) begin
      errors++;
      $display("FAIL rst_val: got %h required 3800", out_posit);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_saturation();
    test_rounding();
    test_specials();
    test_backpressure();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
